// File: rtl/axi_lite_beat_master_if.sv
// AXI4-Lite channel bundle between the beat master and its slave.
// Signal names keep the master-side direction prefix for easy tracing.
interface axi_lite_beat_master_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32
) ();
    logic [AXI_ADDR_WIDTH-1:0]   o_awaddr;
    logic                        o_awvalid;
    logic                        i_awready;
    logic [AXI_DATA_WIDTH-1:0]   o_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] o_wstrb;
    logic                        o_wvalid;
    logic                        i_wready;
    logic [1:0]                  i_bresp;
    logic                        i_bvalid;
    logic                        o_bready;
    logic [AXI_ADDR_WIDTH-1:0]   o_araddr;
    logic                        o_arvalid;
    logic                        i_arready;
    logic [AXI_DATA_WIDTH-1:0]   i_rdata;
    logic [1:0]                  i_rresp;
    logic                        i_rvalid;
    logic                        o_rready;

    modport master (
        output o_awaddr, o_awvalid, o_wdata, o_wstrb, o_wvalid,
        output o_bready, o_araddr, o_arvalid, o_rready,
        input  i_awready, i_wready, i_bresp, i_bvalid,
        input  i_arready, i_rdata, i_rresp, i_rvalid
    );

    modport slave (
        input  o_awaddr, o_awvalid, o_wdata, o_wstrb, o_wvalid,
        input  o_bready, o_araddr, o_arvalid, o_rready,
        output i_awready, i_wready, i_bresp, i_bvalid,
        output i_arready, i_rdata, i_rresp, i_rvalid
    );
endinterface

// File: rtl/axi_lite_beat_master.sv
// Single-beat AXI4-Lite master: one read or write per cache-line word,
// pulsing o_done so the line transfer block can advance.
module axi_lite_beat_master #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_start_read,
    input  logic                      i_start_write,
    input  logic                      i_count_done,
    input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
    input  logic [AXI_DATA_WIDTH-1:0] i_data,
    output logic                      o_done,
    output logic                      o_resp_err,
    output logic [AXI_DATA_WIDTH-1:0] o_data,
    axi_lite_beat_master_if.master    axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic                      err_q, err_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        unique case (state_q)
            IDLE: begin
                // Write wins when both line requests are pending
                if (!i_count_done && i_start_write) begin
                    awaddr_d  = i_addr;
                    wdata_d   = i_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_REQ;
                end else if (!i_count_done && i_start_read) begin
                    araddr_d = i_addr;
                    state_d  = RD_REQ;
                end
            end
            WR_REQ: begin
                if (awvalid_q && axi.i_awready) awvalid_d = 1'b0;
                if (wvalid_q && axi.i_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)    state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (axi.i_bvalid) begin
                    err_d   = |axi.i_bresp;
                    state_d = DONE;
                end
            end
            RD_REQ: begin
                if (axi.i_arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (axi.i_rvalid) begin
                    data_d  = axi.i_rdata;
                    err_d   = |axi.i_rresp;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_done     = (state_q == DONE);
    assign o_resp_err = err_q && (state_q == DONE);
    assign o_data     = data_q;

    assign axi.o_awaddr  = awaddr_q;
    assign axi.o_awvalid = awvalid_q;
    assign axi.o_wdata   = wdata_q;
    assign axi.o_wstrb   = '1;
    assign axi.o_wvalid  = wvalid_q;
    assign axi.o_bready  = (state_q == WR_RESP);
    assign axi.o_araddr  = araddr_q;
    assign axi.o_arvalid = (state_q == RD_REQ);
    assign axi.o_rready  = (state_q == RD_RESP);

endmodule
